avalon_pio_bank: RTL and testbench

//  Parametrised Avalon-MM PIO bank: N_OUT output channels and N_IN input channels, each DATA_W bits.

---
 rtl/avalon_pio_bank.sv | 187 ++++++++++++++++++
 tb/tb_avalon_pio_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_bank.sv
// Avalon-MM PIO bank: N_OUT byte-writable output channels and N_IN synchronised
// input channels with sticky per-bit edge capture (write-1-to-clear) and a
// masked, level-sensitive interrupt. Read latency is one clock.
`timescale 1ns/1ps
module avalon_pio_bank #(
    parameter int                N_OUT     = 6,
    parameter int                N_IN      = 2,
    parameter int                DATA_W    = 32,
    parameter int                EDGE_MODE = 0,
    parameter logic [DATA_W-1:0] OUT_RST   = '0
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [5:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATA_W-1:0]       avs_writedata,
    input  logic [DATA_W/8-1:0]     avs_byteenable,
    output logic [DATA_W-1:0]       avs_readdata,
    output logic                    avs_readdatavalid,
    output logic [N_OUT*DATA_W-1:0] out_export,
    input  logic [N_IN*DATA_W-1:0]  in_export,
    output logic                    irq
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    // Address splits into a 4-word-group selector and a channel index
    logic [1:0]        grp;
    logic [3:0]        idx;
    logic [DATA_W-1:0] be_mask;
    assign grp = avs_address[5:4];
    assign idx = avs_address[3:0];

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_be
            assign be_mask[gi*8 +: 8] = {8{avs_byteenable[gi]}};
        end
    endgenerate

    // Per-channel register views gathered for the read mux and irq reduction
    logic [DATA_W-1:0] out_q  [N_OUT];
    logic [DATA_W-1:0] in_q   [N_IN];
    logic [DATA_W-1:0] cap_q  [N_IN];
    logic [DATA_W-1:0] mask_q [N_IN];

    // Prime FSM: edge detection stays off until the sync chain holds real input levels
    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;

    // State register for the prime FSM
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg <= ST_PRIME;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Count three cycles in PRIME, then remain in RUN until reset
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_PRIME) begin
            if (cnt_reg == 2'd2) begin
                state_next = ST_RUN;
            end else begin
                cnt_next = cnt_reg + 2'd1;
            end
        end
    end

    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            logic              wr_sel;
            logic [DATA_W-1:0] data_reg;
            assign wr_sel = avs_write && (grp == 2'd0) && (idx == 4'(gi));

            // Byte-lane merge of writes into the output register
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    data_reg <= OUT_RST;
                end else if (wr_sel) begin
                    data_reg <= (data_reg & ~be_mask) | (avs_writedata & be_mask);
                end
            end

            assign out_q[gi]                       = data_reg;
            assign out_export[gi*DATA_W +: DATA_W] = data_reg;
        end

        for (gi = 0; gi < N_IN; gi++) begin : g_in
            logic              mask_sel, clr_sel;
            logic [DATA_W-1:0] sync1_reg, sync2_reg, prev_reg, mask_reg, cap_reg;
            logic [DATA_W-1:0] edge_raw, edge_hit, clr_bits;

            assign mask_sel = avs_write && (grp == 2'd3) && (idx == 4'(gi));
            assign clr_sel  = avs_write && (grp == 2'd2) && (idx == 4'(gi));
            assign clr_bits = clr_sel ? (avs_writedata & be_mask) : '0;

            if (EDGE_MODE == 0) begin : g_rise
                assign edge_raw = sync2_reg & ~prev_reg;
            end else if (EDGE_MODE == 1) begin : g_fall
                assign edge_raw = ~sync2_reg & prev_reg;
            end else begin : g_any
                assign edge_raw = sync2_reg ^ prev_reg;
            end
            assign edge_hit = (state_reg == ST_RUN) ? edge_raw : '0;

            // Two-flop synchroniser followed by the previous-value register
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    sync1_reg <= '0;
                    sync2_reg <= '0;
                    prev_reg  <= '0;
                end else begin
                    sync1_reg <= in_export[gi*DATA_W +: DATA_W];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                end
            end

            // Sticky capture; a new edge overrides a simultaneous clear
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    cap_reg <= '0;
                end else begin
                    cap_reg <= (cap_reg & ~clr_bits) | edge_hit;
                end
            end

            // Byte-lane merge of writes into the irq mask
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    mask_reg <= '0;
                end else if (mask_sel) begin
                    mask_reg <= (mask_reg & ~be_mask) | (avs_writedata & be_mask);
                end
            end

            assign in_q[gi]   = sync2_reg;
            assign cap_q[gi]  = cap_reg;
            assign mask_q[gi] = mask_reg;
        end
    endgenerate

    logic [DATA_W-1:0] rd_mux;
    logic              irq_any;

    // Read mux over current register contents; unmapped slots read as zero
    always_comb begin
        rd_mux = '0;
        case (grp)
            2'd0: for (int i = 0; i < N_OUT; i++) if (idx == 4'(i)) rd_mux = out_q[i];
            2'd1: for (int i = 0; i < N_IN; i++)  if (idx == 4'(i)) rd_mux = in_q[i];
            2'd2: for (int i = 0; i < N_IN; i++)  if (idx == 4'(i)) rd_mux = cap_q[i];
            default: for (int i = 0; i < N_IN; i++) if (idx == 4'(i)) rd_mux = mask_q[i];
        endcase
    end

    // Any masked capture bit requests an interrupt
    always_comb begin
        irq_any = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            irq_any = irq_any | (|(cap_q[i] & mask_q[i]));
        end
    end

    // Registered read response and interrupt output
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
            irq <= irq_any;
        end
    end
endmodule

// File: tb/tb_avalon_pio_bank.sv
// Self-checking bench for avalon_pio_bank: directed scenarios followed by a
// randomised bus/input sequence compared against a register-map model.
`timescale 1ns/1ps
module tb_avalon_pio_bank;
    localparam int          N_OUT = 6;
    localparam int          N_IN  = 2;
    localparam int          DW    = 32;
    localparam int          EM    = 0;
    localparam logic [31:0] ORST  = 32'h1100_2200;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [5:0]           avs_address;
    logic                 avs_read, avs_write;
    logic [DW-1:0]        avs_writedata;
    logic [DW/8-1:0]      avs_byteenable;
    logic [DW-1:0]        avs_readdata;
    logic                 avs_readdatavalid;
    logic [N_OUT*DW-1:0]  out_export;
    logic [N_IN*DW-1:0]   in_export;
    logic                 irq;

    avalon_pio_bank #(
        .N_OUT(N_OUT), .N_IN(N_IN), .DATA_W(DW), .EDGE_MODE(EM), .OUT_RST(ORST)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .out_export(out_export),
        .in_export(in_export), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model of the visible register map
    logic [31:0] out_m  [N_OUT];
    logic [31:0] mask_m [N_IN];
    logic [31:0] cap_m  [N_IN];
    logic [31:0] in_m   [N_IN];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] edges(input logic [31:0] old_v, input logic [31:0] new_v);
        if (EM == 0)      return new_v & ~old_v;
        else if (EM == 1) return ~new_v & old_v;
        else              return new_v ^ old_v;
    endfunction

    function automatic logic [31:0] exp_read(input logic [5:0] a);
        int g = int'(a) / 16;
        int i = int'(a) % 16;
        if (g == 0 && i < N_OUT) return out_m[i];
        if (g == 1 && i < N_IN)  return in_m[i];
        if (g == 2 && i < N_IN)  return cap_m[i];
        if (g == 3 && i < N_IN)  return mask_m[i];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        int g = int'(a) / 16;
        int i = int'(a) % 16;
        logic [31:0] bm = lanes(be);
        if (g == 0 && i < N_OUT)     out_m[i]  = (out_m[i] & ~bm) | (d & bm);
        else if (g == 2 && i < N_IN) cap_m[i]  = cap_m[i] & ~(d & bm);
        else if (g == 3 && i < N_IN) mask_m[i] = (mask_m[i] & ~bm) | (d & bm);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) out_m[i] = ORST;
        for (int i = 0; i < N_IN; i++) begin
            mask_m[i] = '0;
            cap_m[i]  = '0;
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
        model_write(a, d, be);
        $display("WR  addr=%02h data=%08h be=%b", a, d, be);
    endtask

    task automatic bus_read(input logic [5:0] a, input string tag);
        logic [31:0] exp;
        exp = exp_read(a);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        chk({tag, "_valid"}, 64'(avs_readdatavalid), 64'd1);
        chk({tag, "_data"}, 64'(avs_readdata), 64'(exp));
        $display("RD  addr=%02h data=%08h exp=%08h", a, avs_readdata, exp);
    endtask

    task automatic set_in(input int ch, input logic [31:0] v, input int hold);
        cap_m[ch] = cap_m[ch] | edges(in_m[ch], v);
        in_m[ch] = v;
        in_export[ch*DW +: DW] = v;
        repeat (hold) tick();
        $display("IN  ch=%0d value=%08h", ch, v);
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < N_OUT; i++) chk(tag, 64'(out_export[i*DW +: DW]), 64'(out_m[i]));
    endtask

    task automatic check_irq(input string tag);
        logic e = 1'b0;
        for (int i = 0; i < N_IN; i++) e = e | (|(cap_m[i] & mask_m[i]));
        chk(tag, 64'(irq), 64'(e));
    endtask

    initial begin
        logic [31:0] pre;
        // 1: reset with all-ones inputs; nothing captures through the prime window
        rst_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0; in_export = '1;
        for (int i = 0; i < N_IN; i++) in_m[i] = '1;
        model_reset();
        repeat (3) tick();
        check_outs("rst_out");
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_valid", 64'(avs_readdatavalid), 64'd0);
        chk("rst_rdata", 64'(avs_readdata), 64'd0);
        rst_n = 1'b1;
        repeat (10) tick();
        bus_read(6'h20, "prime_cap0");
        bus_read(6'h21, "prime_cap1");
        bus_read(6'h10, "in0_sync");
        chk("prime_irq", 64'(irq), 64'd0);

        // 2: byte-enable write and readback
        bus_write(6'h00, 32'hDEAD_BEEF, 4'b0101);
        chk("be_write_ch0", 64'(out_export[31:0]), 64'h11AD_22EF);
        check_outs("be_write");
        bus_read(6'h00, "be_read");

        // Simultaneous read and write of one address returns the old value
        pre = out_m[1];
        avs_address = 6'h01; avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'hF;
        avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        model_write(6'h01, 32'hCAFE_F00D, 4'hF);
        chk("rw_same_valid", 64'(avs_readdatavalid), 64'd1);
        chk("rw_same_data", 64'(avs_readdata), 64'(pre));
        check_outs("rw_same_out");

        // 3: rising edge on ch1 bit0 with mask, irq timing, W1C
        set_in(0, 32'h0, 0);
        set_in(1, 32'h0, 4);
        bus_read(6'h21, "fall_nocap");
        bus_write(6'h31, 32'h1, 4'hF);
        set_in(1, 32'h1, 3);
        chk("irq_before", 64'(irq), 64'd0);
        tick();
        chk("irq_rise", 64'(irq), 64'd1);
        bus_read(6'h21, "cap1_set");
        bus_write(6'h21, 32'h1, 4'hF);
        chk("irq_hold", 64'(irq), 64'd1);
        tick();
        chk("irq_fall", 64'(irq), 64'd0);
        bus_read(6'h21, "cap1_clr");

        // 4: clear colliding with a new edge leaves the bit set
        set_in(1, 32'h0, 4);
        set_in(1, 32'h1, 4);
        set_in(1, 32'h0, 4);
        in_export[DW] = 1'b1;
        in_m[1] = 32'h1;
        tick(); tick();
        bus_write(6'h21, 32'h1, 4'hF);
        cap_m[1] = cap_m[1] | 32'h1;
        bus_read(6'h21, "edge_wins");
        check_irq("edge_wins_irq");

        // 5: unmapped and out-of-range accesses
        bus_read(6'h3F, "rd_3f");
        bus_read(6'h0A, "rd_0a");
        bus_read(6'h12, "rd_12");
        chk("rd_12_zero", 64'(avs_readdata), 64'd0);
        bus_read(6'h06, "rd_06");
        bus_write(6'h0A, 32'hFFFF_FFFF, 4'hF);
        bus_write(6'h12, 32'hFFFF_FFFF, 4'hF);
        check_outs("oor_write");

        // Randomised mix of writes, input changes, clears and reads
        for (int n = 0; n < 40; n++) begin
            int op = int'($urandom_range(0, 3));
            case (op)
                0: bus_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
                1: set_in(int'($urandom_range(0, N_IN - 1)), $urandom, 4);
                2: bus_write(6'(32 + $urandom_range(0, 2)), $urandom, 4'($urandom_range(0, 15)));
                default: bus_read(6'($urandom_range(0, 63)), "rnd_rd");
            endcase
            tick();
            check_irq("rnd_irq");
            check_outs("rnd_out");
        end
        for (int a = 0; a < 64; a += 16) begin
            bus_read(6'(a), "sweep_g");
            bus_read(6'(a + 1), "sweep_g1");
        end

        // 6: reset between read request and its response
        set_in(0, 32'hFFFF_FFFF, 0);
        set_in(1, 32'hFFFF_FFFF, 4);
        avs_address = 6'h00; avs_read = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        avs_read = 1'b0;
        model_reset();
        chk("rst_mid_valid", 64'(avs_readdatavalid), 64'd0);
        tick();
        chk("rst_mid_valid2", 64'(avs_readdatavalid), 64'd0);
        chk("rst_mid_rdata", 64'(avs_readdata), 64'd0);
        check_outs("rst_mid_out");
        rst_n = 1'b1;
        chk("rst_mid_valid3", 64'(avs_readdatavalid), 64'd0);
        repeat (10) tick();
        bus_read(6'h20, "rerst_cap0");
        bus_read(6'h21, "rerst_cap1");
        bus_read(6'h30, "rerst_mask0");
        chk("rerst_irq", 64'(irq), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
